// File: rtl/mmcm_drp_reconfig.sv
// -----------------------------------------------------------------------------
// mmcm_drp_reconfig
//
// DRP master for an MMCME2_ADV. Holds the MMCM in reset, applies a small table
// of read-modify-write register updates over the DRP, then releases the reset
// and waits for lock. Runs entirely in the DRP clock domain.
//
// Ports:
//   clk, rst_n            DRP clock, asynchronous active-low reset
//   cfg_we/idx/daddr/     table write port (ignored unless idle):
//   cfg_mask/cfg_data     mask bit 1 keeps the MMCM bit, 0 takes cfg_data
//   start, count          launch a sequence over entries 0..count-1
//   busy, done, error     status: busy while working, done pulse, sticky error
//   mmcm_rst              MMCM RST output
//   drp_*                 DRP master interface
//   mmcm_locked           MMCM LOCKED (asynchronous, synchronized here)
// -----------------------------------------------------------------------------
module mmcm_drp_reconfig #(
    parameter int  DEPTH        = 16,
    parameter int  DRDY_TIMEOUT = 64,
    parameter int  LOCK_TIMEOUT = 65536,
    parameter int  RST_HOLD     = 4,
    localparam int IW           = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_we,
    input  logic [IW-1:0] cfg_idx,
    input  logic [6:0]    cfg_daddr,
    input  logic [15:0]   cfg_mask,
    input  logic [15:0]   cfg_data,
    input  logic          start,
    input  logic [IW:0]   count,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic          mmcm_rst,
    output logic [6:0]    drp_daddr,
    output logic [15:0]   drp_di,
    output logic          drp_den,
    output logic          drp_dwe,
    input  logic [15:0]   drp_do,
    input  logic          drp_drdy,
    input  logic          mmcm_locked
);

    typedef enum logic [3:0] {
        S_IDLE, S_RST_ON, S_RD, S_RD_WAIT, S_WR, S_WR_WAIT,
        S_RELEASE, S_LOCK_WAIT, S_FIN
    } state_e;

    typedef struct packed {
        logic [6:0]  daddr;
        logic [15:0] mask;
        logic [15:0] data;
    } entry_t;

    localparam logic [IW:0] DEPTH_W = (IW+1)'(DEPTH);
    localparam logic [IW:0] IDX_ONE = (IW+1)'(1);

    entry_t      table_mem [DEPTH];

    state_e      state_q, state_d;
    logic [IW:0] count_q, count_d;
    logic [IW:0] idx_q, idx_d;
    logic [31:0] cnt_q, cnt_d;         // shared by reset hold, drdy and lock timeouts
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        mmcm_rst_q, mmcm_rst_d;
    logic        den_q, den_d;
    logic        dwe_q, dwe_d;
    logic [6:0]  daddr_q, daddr_d;
    logic [15:0] di_q, di_d;
    logic        drdy_q, drdy_d;
    logic [15:0] do_q;
    logic        locked_s1_q, locked_s2_q;
    logic        start_ok;

    assign start_ok = start && (state_q == S_IDLE);

    // NOTE: the table is plain storage with no reset; its contents are
    // undefined until written, so adding a reset would only cost routing.
    always_ff @(posedge clk) begin
        if (cfg_we && (state_q == S_IDLE) && !start) begin
            table_mem[cfg_idx] <= '{daddr: cfg_daddr, mask: cfg_mask, data: cfg_data};
        end
    end

    // drdy is qualified by the wait states when registered, so a stray drdy
    // elsewhere never reaches the FSM. Registering the DRP returns costs one
    // cycle per access but keeps the bus inputs off the FSM critical path.
    assign drdy_d = drp_drdy && ((state_q == S_RD_WAIT) || (state_q == S_WR_WAIT));

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can infer a latch.
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + 32'd1;
        error_d = error_q;
        daddr_d = daddr_q;
        di_d    = di_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start_ok) begin
                    count_d = (count > DEPTH_W) ? DEPTH_W : count;
                    error_d = 1'b0;
                    idx_d   = '0;
                    state_d = S_RST_ON;
                end
            end
            S_RST_ON: begin
                if (cnt_q == 32'(RST_HOLD - 1)) begin
                    cnt_d   = '0;
                    state_d = (count_q == '0) ? S_RELEASE : S_RD;
                end
            end
            S_RD, S_WR: begin
                cnt_d   = '0;
                state_d = (state_q == S_RD) ? S_RD_WAIT : S_WR_WAIT;
            end
            S_RD_WAIT: begin
                if (drdy_q) begin
                    di_d    = (do_q & table_mem[idx_q[IW-1:0]].mask)
                            | (table_mem[idx_q[IW-1:0]].data & ~table_mem[idx_q[IW-1:0]].mask);
                    state_d = S_WR;
                end else if (cnt_q == 32'(DRDY_TIMEOUT)) begin
                    error_d = 1'b1;
                    state_d = S_RELEASE;
                end
            end
            S_WR_WAIT: begin
                if (drdy_q) begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = (idx_d < count_q) ? S_RD : S_RELEASE;
                end else if (cnt_q == 32'(DRDY_TIMEOUT)) begin
                    error_d = 1'b1;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                cnt_d   = '0;
                state_d = S_LOCK_WAIT;
            end
            S_LOCK_WAIT: begin
                if (locked_s2_q) begin
                    state_d = S_FIN;
                end else if (cnt_q == 32'(LOCK_TIMEOUT - 1)) begin
                    error_d = 1'b1;
                    state_d = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        den_d      = (state_d == S_RD) || (state_d == S_WR);
        dwe_d      = (state_d == S_WR);
        mmcm_rst_d = state_d inside {S_RST_ON, S_RD, S_RD_WAIT, S_WR, S_WR_WAIT};
        busy_d     = !(state_d inside {S_IDLE, S_FIN});
        done_d     = (state_d == S_FIN);
        if (state_d == S_RD) begin
            daddr_d = table_mem[idx_d[IW-1:0]].daddr;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            mmcm_rst_q  <= 1'b0;
            den_q       <= 1'b0;
            dwe_q       <= 1'b0;
            daddr_q     <= '0;
            di_q        <= '0;
            drdy_q      <= 1'b0;
            do_q        <= '0;
            locked_s1_q <= 1'b0;
            locked_s2_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            mmcm_rst_q  <= mmcm_rst_d;
            den_q       <= den_d;
            dwe_q       <= dwe_d;
            daddr_q     <= daddr_d;
            di_q        <= di_d;
            drdy_q      <= drdy_d;
            do_q        <= drp_do;
            locked_s1_q <= mmcm_locked;
            locked_s2_q <= locked_s1_q;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign mmcm_rst  = mmcm_rst_q;
    assign drp_den   = den_q;
    assign drp_dwe   = dwe_q;
    assign drp_daddr = daddr_q;
    assign drp_di    = di_q;

endmodule

// File: tb/tb_mmcm_drp_reconfig.sv
// -----------------------------------------------------------------------------
// tb_mmcm_drp_reconfig
//
// Directed bench for mmcm_drp_reconfig. A negedge-driven DRP slave / MMCM
// model answers accesses, logs every den and tracks reset and lock timing;
// one linear initial block applies the scenarios and checks the results.
// -----------------------------------------------------------------------------
module tb_mmcm_drp_reconfig;

    localparam int DEPTH        = 16;
    localparam int DRDY_TIMEOUT = 16;
    localparam int LOCK_TIMEOUT = 200;
    localparam int RST_HOLD     = 4;
    localparam int IW           = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_we = 1'b0;
    logic [IW-1:0] cfg_idx = '0;
    logic [6:0]    cfg_daddr = '0;
    logic [15:0]   cfg_mask = '0;
    logic [15:0]   cfg_data = '0;
    logic          start = 1'b0;
    logic [IW:0]   count = '0;
    logic          busy, done, error, mmcm_rst;
    logic [6:0]    drp_daddr;
    logic [15:0]   drp_di;
    logic          drp_den, drp_dwe;
    logic [15:0]   drp_do = '0;
    logic          drp_drdy = 1'b0;
    logic          mmcm_locked = 1'b0;

    always #5 clk = ~clk;

    mmcm_drp_reconfig #(
        .DEPTH(DEPTH), .DRDY_TIMEOUT(DRDY_TIMEOUT),
        .LOCK_TIMEOUT(LOCK_TIMEOUT), .RST_HOLD(RST_HOLD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_daddr(cfg_daddr),
        .cfg_mask(cfg_mask), .cfg_data(cfg_data),
        .start(start), .count(count),
        .busy(busy), .done(done), .error(error), .mmcm_rst(mmcm_rst),
        .drp_daddr(drp_daddr), .drp_di(drp_di), .drp_den(drp_den), .drp_dwe(drp_dwe),
        .drp_do(drp_do), .drp_drdy(drp_drdy), .mmcm_locked(mmcm_locked)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- DRP slave / MMCM model ----------------
    logic [15:0] model_regs [128] = '{default: 16'hFFFF};
    logic [23:0] log_q [$];            // {we, addr, di-if-write}
    int          den_cyc_q [$];
    int          cyc = 0;
    int          busy_cnt = 0;
    bit          drop = 1'b0;
    logic [6:0]  pend_addr = '0;
    bit          prev_den = 1'b0;
    bit          prev_rst = 1'b0;
    int          rst_rise_cyc = 0, rst_fall_cyc = 0, done_cyc = 0;
    int          b2b = 0, den_norst = 0, done_pulses = 0, rd_num = 0;
    int          lock_cnt = 0;
    int          suppress_rd = -1;     // read number (absolute) left unanswered
    int          drdy_lat = 2;
    bit          hold_unlocked = 1'b0;

    always @(negedge clk) begin
        cyc++;
        drp_drdy = 1'b0;
        if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0 && !drop) begin
                drp_drdy = 1'b1;
                drp_do   = model_regs[pend_addr];
            end
        end
        if (drp_den === 1'b1) begin
            den_cyc_q.push_back(cyc);
            log_q.push_back({drp_dwe, drp_daddr, (drp_dwe ? drp_di : 16'h0)});
            if (prev_den) b2b++;
            if (mmcm_rst !== 1'b1) den_norst++;
            pend_addr = drp_daddr;
            busy_cnt  = drdy_lat;
            drop      = 1'b0;
            if (drp_dwe === 1'b1) begin
                model_regs[drp_daddr] = drp_di;
            end else begin
                if (rd_num == suppress_rd) drop = 1'b1;
                rd_num++;
            end
        end
        prev_den = (drp_den === 1'b1);
        if (mmcm_rst === 1'b1 && !prev_rst) rst_rise_cyc = cyc;
        if (mmcm_rst !== 1'b1 && prev_rst)  rst_fall_cyc = cyc;
        prev_rst = (mmcm_rst === 1'b1);
        if (done === 1'b1) begin
            done_cyc = cyc;
            done_pulses++;
        end
        if (mmcm_rst === 1'b1 || hold_unlocked) begin
            mmcm_locked = 1'b0;
            lock_cnt    = 0;
        end else if (lock_cnt < 5) begin
            lock_cnt++;
        end else begin
            mmcm_locked = 1'b1;
        end
    end

    function automatic logic [23:0] enc(input logic we, input logic [6:0] a, input logic [15:0] d);
        return {we, a, d};
    endfunction

    function automatic logic [23:0] log_at(input int i);
        return (i < log_q.size()) ? log_q[i] : 24'hFFFFFF;
    endfunction

    function automatic int den_cyc_at(input int i);
        return (i < den_cyc_q.size()) ? den_cyc_q[i] : -1;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic write_entry(input int idx, input logic [6:0] a, input logic [15:0] m,
                               input logic [15:0] d);
        cfg_we = 1'b1; cfg_idx = idx[IW-1:0]; cfg_daddr = a; cfg_mask = m; cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic start_run(input int n);
        start = 1'b1; count = n[IW:0];
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max, output logic err);
        bit seen = 1'b0;
        err = 1'bx;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                err  = error;
                break;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},  32'(busy),      32'd0);
        check({tag, "_done"},  32'(done),      32'd0);
        check({tag, "_error"}, 32'(error),     32'd0);
        check({tag, "_rst"},   32'(mmcm_rst),  32'd0);
        check({tag, "_den"},   32'(drp_den),   32'd0);
        check({tag, "_dwe"},   32'(drp_dwe),   32'd0);
        check({tag, "_daddr"}, 32'(drp_daddr), 32'd0);
        check({tag, "_di"},    32'(drp_di),    32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before the summary line");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic        e;
        logic        found;
        int          base, b2b0, nr0, dp0, dt;
        logic [23:0] exp6 [6];

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // T1: single entry, read then masked write
        write_entry(0, 7'h08, 16'h1000, 16'h0041);
        base = log_q.size(); b2b0 = b2b; nr0 = den_norst; dp0 = done_pulses;
        start_run(1);
        check("t1_busy_after_start", 32'(busy), 32'd1);
        check("t1_rst_after_start", 32'(mmcm_rst), 32'd1);
        wait_done("t1", 500, e);
        check("t1_error", 32'(e), 32'd0);
        @(negedge clk);
        check("t1_den_count", 32'(log_q.size() - base), 32'd2);
        check("t1_read", 32'(log_at(base)), 32'(enc(1'b0, 7'h08, 16'h0)));
        check("t1_write", 32'(log_at(base + 1)), 32'(enc(1'b1, 7'h08, 16'h1041)));
        check("t1_first_den_delay", 32'(den_cyc_at(base) - rst_rise_cyc), 32'(RST_HOLD));
        check("t1_den_outside_rst", 32'(den_norst - nr0), 32'd0);
        check("t1_done_pulses", 32'(done_pulses - dp0), 32'd1);
        check("t1_busy_after_done", 32'(busy), 32'd0);

        // T2: three entries, order, spacing, no back-to-back den
        write_entry(1, 7'h09, 16'hFF00, 16'h00AB);
        write_entry(2, 7'h14, 16'h0000, 16'h1234);
        exp6[0] = enc(1'b0, 7'h08, 16'h0);  exp6[1] = enc(1'b1, 7'h08, 16'h1041);
        exp6[2] = enc(1'b0, 7'h09, 16'h0);  exp6[3] = enc(1'b1, 7'h09, 16'hFFAB);
        exp6[4] = enc(1'b0, 7'h14, 16'h0);  exp6[5] = enc(1'b1, 7'h14, 16'h1234);
        base = log_q.size(); b2b0 = b2b;
        start_run(3);
        wait_done("t2", 500, e);
        check("t2_error", 32'(e), 32'd0);
        @(negedge clk);
        check("t2_den_count", 32'(log_q.size() - base), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t2_den%0d", i), 32'(log_at(base + i)), 32'(exp6[i]));
        end
        check("t2_rd_to_wr", 32'(den_cyc_at(base + 1) - den_cyc_at(base)), 32'd4);
        check("t2_entry_cost", 32'(den_cyc_at(base + 2) - den_cyc_at(base)), 32'd8);
        check("t2_back_to_back", 32'(b2b - b2b0), 32'd0);

        // T3: second read never answered -> drdy timeout
        base = log_q.size();
        suppress_rd = rd_num + 1;
        start_run(3);
        wait_done("t3", 500, e);
        check("t3_error", 32'(e), 32'd1);
        @(negedge clk);
        suppress_rd = -1;
        check("t3_den_count", 32'(log_q.size() - base), 32'd3);
        check("t3_rst_fall_delay", 32'(rst_fall_cyc - den_cyc_at(base + 2)), 32'(DRDY_TIMEOUT + 2));
        check("t3_error_sticky", 32'(error), 32'd1);
        start_run(1);
        check("t3_error_cleared", 32'(error), 32'd0);
        wait_done("t3b", 500, e);
        check("t3b_error", 32'(e), 32'd0);
        @(negedge clk);

        // T4: lock never arrives -> lock timeout
        hold_unlocked = 1'b1;
        start_run(1);
        wait_done("t4", LOCK_TIMEOUT + 100, e);
        check("t4_error", 32'(e), 32'd1);
        @(negedge clk);
        hold_unlocked = 1'b0;
        dt = done_cyc - rst_fall_cyc;
        check("t4_lock_window", 32'(dt >= LOCK_TIMEOUT - 3 && dt <= LOCK_TIMEOUT + 3), 32'd1);

        // T5: count = 0, reset pulse only
        base = log_q.size();
        start_run(0);
        wait_done("t5", 500, e);
        check("t5_error", 32'(e), 32'd0);
        @(negedge clk);
        check("t5_den_count", 32'(log_q.size() - base), 32'd0);
        check("t5_rst_width", 32'(rst_fall_cyc - rst_rise_cyc), 32'(RST_HOLD));

        // T6: count above DEPTH clamps to DEPTH
        for (int i = 3; i < DEPTH; i++) write_entry(i, 7'(32 + i), 16'hFFFF, 16'h0000);
        base = log_q.size();
        start_run(20);
        wait_done("t6", 2000, e);
        check("t6_error", 32'(e), 32'd0);
        @(negedge clk);
        check("t6_den_count", 32'(log_q.size() - base), 32'(2 * DEPTH));
        check("t6_last_write", 32'(log_at(base + 2 * DEPTH - 1)), 32'(enc(1'b1, 7'h2F, 16'hFFFF)));

        // T7: asynchronous reset during WR_WAIT, then a clean run
        start_run(1);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (drp_den === 1'b1 && drp_dwe === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        check("t7_write_seen", 32'(found), 32'd1);
        @(negedge clk);
        check("t7_busy_in_wr_wait", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("t7_async");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        write_entry(0, 7'h08, 16'h1000, 16'h0041);
        base = log_q.size();
        start_run(1);
        wait_done("t7b", 500, e);
        check("t7b_error", 32'(e), 32'd0);
        @(negedge clk);
        check("t7b_den_count", 32'(log_q.size() - base), 32'd2);
        check("t7b_write", 32'(log_at(base + 1)), 32'(enc(1'b1, 7'h08, 16'h1041)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
